// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: md_op encoding, widths and default latencies.
// Also used by the control unit and the D-stage hazard unit.
package mdu_unit_pkg;

  localparam int XLEN            = 32;
  localparam int OP_W            = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // The accumulate codes always exist so the encoding stays stable across builds.
  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage request/response bundle between the pipeline and the MDU.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  logic [OP_W-1:0] md_op;
  logic            flush;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            start;
  logic            busy;
  logic [XLEN-1:0] md_out;

  modport master (output md_op, flush, src_a, src_b, input start, busy, md_out);
  modport slave  (input md_op, flush, src_a, src_b, output start, busy, md_out);
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit HI/LO result generator for mul/div (and madd/msub when
// MDU_MADD_EN is defined). Divide by zero returns the incoming HI/LO unchanged.
module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic            signed_op;
  logic            b_nz;
  logic [63:0]     a_ext, b_ext, prod, res;
  logic [XLEN-1:0] mag_a, mag_b, uq, ur, q, r;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
`ifdef MDU_MADD_EN
    signed_op = signed_op || (op == MD_MADD) || (op == MD_MSUB);
`endif
    b_nz  = |b;
    a_ext = signed_op ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext = signed_op ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = a_ext * b_ext;

    // Divide on magnitudes so 0x80000000 / -1 cannot overflow the quotient.
    mag_a = (signed_op && a[XLEN-1]) ? -a : a;
    mag_b = (signed_op && b[XLEN-1]) ? -b : b;
    if (!b_nz) mag_b = 32'd1;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    q     = (signed_op && (a[XLEN-1] ^ b[XLEN-1])) ? -uq : uq;
    r     = (signed_op && a[XLEN-1]) ? -ur : ur;

    res = {hi, lo};
    case (op)
      MD_MULT, MD_MULTU: res = prod;
      MD_DIV, MD_DIVU:   res = b_nz ? {r, q} : {hi, lo};
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: res = {hi, lo} + prod;
      MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
      default:           res = {hi, lo};
    endcase
    res_hi = res[63:32];
    res_lo = res[31:0];
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mul/div ops and
// drives start/busy for the hazard unit. Optional accumulate ops: MDU_MADD_EN.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  mdu_unit_if.slave       md,
  output logic [XLEN-1:0] hi_q,
  output logic [XLEN-1:0] lo_q
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [XLEN-1:0] calc_hi, calc_lo;
  logic [OP_W-1:0] op_eff;
  logic            idle;

  assign op_eff   = md.flush ? MD_NONE : md.md_op;
  assign idle     = (state_q == ST_IDLE);
  assign md.start = idle && (is_mul_op(op_eff) || is_div_op(op_eff));
  assign md.busy  = (state_q == ST_BUSY);

  always_comb begin
    md.md_out = '0;
    if (op_eff == MD_MFHI)      md.md_out = hi_q;
    else if (op_eff == MD_MFLO) md.md_out = lo_q;
  end

  mdu_calc u_calc (
    .op     (op_eff),
    .a      (md.src_a),
    .b      (md.src_b),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          cnt_d     = is_div_op(op_eff) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d   = ST_BUSY;
        end else if (op_eff == MD_MTHI) begin
          hi_d = md.src_a;
        end else if (op_eff == MD_MTLO) begin
          lo_d = md.src_a;
        end
      end
      ST_BUSY: begin
        // Anything arriving while busy is a stalled bubble and is dropped.
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the pending result is reset too, so an aborted op
  // leaves no stale value that could later commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table with a HI/LO scoreboard plus
// hand-written sequences for divide-by-zero, flush, MT-while-busy and reset abort.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] hi_q, lo_q;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    int              n;
    logic [63:0]     exp;
  } vec_t;

  vec_t vecs[8];

  mdu_unit_if mif ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif),
    .hi_q    (hi_q),
    .lo_q    (lo_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A start-class op must never sit unflushed in E while the unit is busy.
  always @(negedge clk) begin
    if (reset_n && mif.busy && !mif.flush &&
        (mif.md_op == MD_MULT || mif.md_op == MD_MULTU ||
         mif.md_op == MD_DIV  || mif.md_op == MD_DIVU)) begin
      mismatched++;
      $display("FAIL illegal_start_while_busy: md_op %0d reached E while busy", mif.md_op);
    end
  end

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (mif.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [63:0] exp, input string name);
    int          cyc;
    logic [63:0] want;
    @(negedge clk);
    mif.md_op = op; mif.src_a = a; mif.src_b = b;
    #1 check({name, " start"}, 64'(mif.start), 64'd1);
    sb_q.push_back(exp);
    @(negedge clk);
    mif.md_op = MD_NONE;
    wait_idle(cyc);
    check({name, " busy_cycles"}, 64'(cyc), 64'(n));
    want = sb_q.pop_front();
    check({name, " hilo"}, {hi_q, lo_q}, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        MC, 64'hFFFFFFFF_FFFFFFFA};
    vecs[1] = '{MD_DIVU,  32'd17,       32'd5,        DC, 64'h00000002_00000003};
    vecs[2] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, DC, 64'h00000000_80000000};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        DC, 64'hFFFFFFFF_FFFFFFFD};
    vecs[4] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 64'hFFFFFFFE_00000001};
    vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, DC, 64'h00000001_FFFFFFFD};
    vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, MC, 64'h40000000_00000000};
    vecs[7] = '{MD_DIVU,  32'hFFFFFFFF, 32'd16,       DC, 64'h0000000F_0FFFFFFF};

    reset_n = 1'b0;
    mif.md_op = MD_NONE; mif.flush = 1'b0; mif.src_a = '0; mif.src_b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset start", 64'(mif.start), 64'd0);
    check("reset hilo", {hi_q, lo_q}, 64'd0);
    check("reset md_out", 64'(mif.md_out), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));

    // DIVU then read back through md_out.
    run_op(MD_DIVU, 32'd17, 32'd5, DC, 64'h00000002_00000003, "divu_mf");
    @(negedge clk); mif.md_op = MD_MFLO;
    #1 check("mflo md_out", 64'(mif.md_out), 64'd3);
    check("mflo start", 64'(mif.start), 64'd0);
    @(negedge clk); mif.md_op = MD_MFHI;
    #1 check("mfhi md_out", 64'(mif.md_out), 64'd2);

    // MTHI, then divide by zero keeps HI/LO.
    @(negedge clk); mif.md_op = MD_MTHI; mif.src_a = 32'h12345678;
    #1 check("mthi start", 64'(mif.start), 64'd0);
    @(negedge clk); mif.md_op = MD_NONE;
    check("mthi busy", 64'(mif.busy), 64'd0);
    check("mthi hilo", {hi_q, lo_q}, 64'h12345678_00000003);
    run_op(MD_DIV, 32'd99, 32'd0, DC, 64'h12345678_00000003, "div_by_zero");

    // Flushed MULT and flushed MTHI do nothing.
    @(negedge clk); mif.md_op = MD_MULT; mif.src_a = 32'd2; mif.src_b = 32'd2; mif.flush = 1'b1;
    #1 check("flush start", 64'(mif.start), 64'd0);
    @(negedge clk); mif.md_op = MD_MTHI; mif.src_a = 32'h0000FFFF;
    check("flush busy", 64'(mif.busy), 64'd0);
    @(negedge clk); mif.md_op = MD_NONE; mif.flush = 1'b0;
    check("flush hilo", {hi_q, lo_q}, 64'h12345678_00000003);

    // MTLO while busy is ignored.
    @(negedge clk); mif.md_op = MD_MULT; mif.src_a = 32'd6; mif.src_b = 32'd7;
    #1 check("mtlo_busy start", 64'(mif.start), 64'd1);
    @(negedge clk); mif.md_op = MD_MTLO; mif.src_a = 32'hDEADBEEF;
    #1 check("mtlo_busy start_low", 64'(mif.start), 64'd0);
    @(negedge clk); mif.md_op = MD_NONE;
    wait_idle(cyc);
    check("mtlo_busy busy_cycles", 64'(cyc), 64'(MC - 1));
    check("mtlo_busy hilo", {hi_q, lo_q}, 64'h00000000_0000002A);

    // Reset in busy cycle 3 of MULTU aborts the op for good.
    @(negedge clk); mif.md_op = MD_MULTU; mif.src_a = 32'hFFFFFFFF; mif.src_b = 32'hFFFFFFFF;
    #1 check("abort start", 64'(mif.start), 64'd1);
    @(negedge clk); mif.md_op = MD_NONE;
    check("abort busy1", 64'(mif.busy), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1 check("abort busy_now", 64'(mif.busy), 64'd0);
    check("abort hilo_now", {hi_q, lo_q}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort busy_later", 64'(mif.busy), 64'd0);
    check("abort hilo_later", {hi_q, lo_q}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Drives the Start/Busy pair that the D-stage hazard unit uses to hold md/mt/mf instructions.
- Downstream of the E pipeline register; the mfhi/mflo result feeds the E-stage result mux toward M.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (>=1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- md_op  input  4  E-stage MDU operation; encoding is in the shared package (NONE=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- flush  input  1  E-stage instruction is a bubble; when high, md_op is treated as NONE.
- src_a  input  32  forwarded rs value.
- src_b  input  32  forwarded rt value.
- start  output  1  combinational; high when md_op is MULT/MULTU/DIV/DIVU, flush=0 and busy=0.
- busy  output  1  registered; high while an operation is in flight.
- md_out  output  32  combinational; HI for MFHI, LO for MFLO, else 0.
- hi_q  output  32  current HI register (debug/trace).
- lo_q  output  32  current LO register (debug/trace).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, cnt=0, HI=0, LO=0; pending results cleared. Applies mid-operation; the aborted operation never commits.
- FSM states: IDLE, BUSY.
- IDLE with start=1 at an edge:
  - Compute the result from src_a/src_b.
  - Latch it into pending_hi/pending_lo.
  - Load cnt with MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy<=1; go to BUSY.
- BUSY: cnt decrements each edge.
  - At the edge where cnt==0: HI<=pending_hi, LO<=pending_lo, busy<=0, go to IDLE.
  - Busy is therefore high for exactly N cycles, starting the cycle after start.
- Latency: an op started in cycle t commits at the end of cycle t+N. mfhi/mflo in E during cycle t+N+1 reads the new value.
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (src_b==0, DIV or DIVU): the op runs its full DIV_CYCLES with busy, but HI/LO keep their prior values at commit.
- MTHI/MTLO in IDLE: HI or LO <= src_a at the next edge. They produce no busy and no start.
- MTHI/MTLO while busy: ignored. The hazard unit prevents this case.
- MFHI/MFLO are purely combinational from current HI/LO. Same-cycle MT writes are not bypassed.
- Start-class md_op while busy: start=0, and the op is ignored. It is legal only as a stalled bubble and must not reach E unflushed; the bench asserts it never does.
- flush=1 suppresses start and MT writes in the same cycle.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: adds md_op codes MADD, MADDU, MSUB, MSUBU, each with MULT_CYCLES latency.
  - Pending result = {HI,LO} ± product, with HI/LO sampled at start.
  - 64-bit wrap-around; signed or unsigned product per op.
  - The start output includes these codes.
- Undefined: these codes decode as NONE; no accumulate datapath is synthesized.

Decomposition:
- Shared package (reused by the CU and hazard unit):
  - md_op encoding constants.
  - Width constants.
  - Default MULT_CYCLES/DIV_CYCLES.
- One natural sub-module, mdu_calc: combinational 64-bit result generator (mul/div/madd, divide-by-zero hold). mdu_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULT src_a=0xFFFFFFFE(-2), src_b=3 -> start=1 one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU 17/5 then MFLO/MFHI -> busy 10 cycles; LO=3, HI=2; md_out=3, then 2.
- DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0x12345678, then DIV x/0 -> after 10 busy cycles HI still 0x12345678, LO unchanged.
- reset_n pulsed low at busy cycle 3 of MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy=0 immediately, HI=LO=0, no later commit.
- MULT issued with flush=1, and MTLO while busy -> start=0, busy=0, HI/LO unchanged; MTLO has no effect.
